// File: rtl/if_stage_pkg.sv
// Shared types for the fetch stage: word/IF-ID register layouts and fetch FSM states.
package if_stage_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t inst;
    logic  vld;
  } if_id_reg_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} fetch_state_e;

  localparam word_t NOP_INST = 32'h0000_0013;

  function automatic if_id_reg_t make_bubble(input word_t pc);
    if_id_reg_t b;
    b.pc   = pc;
    b.inst = NOP_INST;
    b.vld  = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding imem requests and fills IF/ID,
// honouring stall from the hazard unit and redirect (which also flushes IF/ID) from EX.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [64:0] o_if_id
);

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        hold_q, hold_d;
  logic         kill_q, kill_d;
  if_id_reg_t   if_id_q, if_id_d;

  logic  req;
  word_t addr;
  logic  deliver;
  word_t deliver_inst;
  word_t redirect_pc;
  word_t pc_plus4;

  assign redirect_pc = i_redirect_pc & 32'hFFFF_FFFC;
  assign pc_plus4    = pc_q + 32'd4;

  // kill_q marks the outstanding response as belonging to a path that was redirected away.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_d       = hold_q;
    kill_d       = kill_q;
    req          = 1'b0;
    addr         = pc_q;
    deliver      = 1'b0;
    deliver_inst = NOP_INST;

    case (state_q)
      S_IDLE: begin
        req     = 1'b1;
        state_d = S_WAIT;
        if (i_redirect) begin
          addr = redirect_pc;
          pc_d = redirect_pc;
        end
      end

      S_WAIT: begin
        if (!i_imem_rvalid) begin
          if (i_redirect) begin
            pc_d   = redirect_pc;
            kill_d = 1'b1;
          end
        end else if (kill_q || i_redirect) begin
          kill_d = 1'b0;
          req    = 1'b1;
          if (i_redirect) begin
            addr = redirect_pc;
            pc_d = redirect_pc;
          end
        end else if (!i_stall) begin
          deliver      = 1'b1;
          deliver_inst = i_imem_rdata;
          req          = 1'b1;
          addr         = pc_plus4;
          pc_d         = pc_plus4;
        end else begin
          hold_d  = i_imem_rdata;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (i_redirect) begin
          req     = 1'b1;
          addr    = redirect_pc;
          pc_d    = redirect_pc;
          state_d = S_WAIT;
        end else if (!i_stall) begin
          deliver      = 1'b1;
          deliver_inst = hold_q;
          req          = 1'b1;
          addr         = pc_plus4;
          pc_d         = pc_plus4;
          state_d      = S_WAIT;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (i_redirect) begin
      if_id_d = make_bubble(pc_q);
    end else if (i_stall) begin
      if_id_d = if_id_q;
    end else if (deliver) begin
      if_id_d.pc   = pc_q;
      if_id_d.inst = deliver_inst;
      if_id_d.vld  = 1'b1;
    end else begin
      if_id_d = make_bubble(pc_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      hold_q  <= NOP_INST;
      kill_q  <= 1'b0;
      if_id_q <= make_bubble(32'h0000_0000);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      kill_q  <= kill_d;
      if_id_q <= if_id_d;
    end
  end

  assign o_imem_req  = req & ~i_reset;
  assign o_imem_addr = addr;
  assign o_if_id     = if_id_q;

endmodule
